// File: rtl/pipeline_ctrl_m.sv
// ID-stage controller for the RV32IM pipeline: instruction decode, branch
// resolution, load-use stalls, reset-hold sequence and the MUL/DIV handshake.
module pipeline_ctrl_m #(
   parameter int XLEN         = 32,
   parameter int RESET_CYCLES = 2,
   parameter int ENABLE_M     = 1,
   parameter int MDU_TIMEOUT  = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [6:0]      opcode_,
   input  logic [2:0]      funct3_,
   input  logic [6:0]      funct7_,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      ex_rd,
   input  logic            ex_is_load,
   input  logic            mdu_done,
   output logic            rst_pc_,
   output logic            sel_pc_,
   output logic            sel_jump_,
   output logic            stall_pc_,
   output logic            stall_IFID_,
   output logic            flush_IFID_,
   output logic            flush_IDEX_,
   output logic            write_regf_en_,
   output logic            write_ram_,
   output logic            sel_alu_a_,
   output logic [1:0]      sel_alu_b_,
   output logic [1:0]      sel_rd_value_,
   output logic [3:0]      op_,
   output logic            mdu_start_,
   output logic            illegal_,
   output logic            mdu_timeout_
);

   localparam logic [3:0] ALUOP_ADD  = 4'd0;
   localparam logic [3:0] ALUOP_SUB  = 4'd1;
   localparam logic [3:0] ALUOP_SLL  = 4'd2;
   localparam logic [3:0] ALUOP_SLT  = 4'd3;
   localparam logic [3:0] ALUOP_SLTU = 4'd4;
   localparam logic [3:0] ALUOP_XOR  = 4'd5;
   localparam logic [3:0] ALUOP_SRL  = 4'd6;
   localparam logic [3:0] ALUOP_SRA  = 4'd7;
   localparam logic [3:0] ALUOP_OR   = 4'd8;
   localparam logic [3:0] ALUOP_AND  = 4'd9;
   localparam logic [3:0] ALUOP_B    = 4'd10;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam int CNT_MAX = (RESET_CYCLES > MDU_TIMEOUT) ? RESET_CYCLES : MDU_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(MDU_TIMEOUT - 1);

   typedef enum logic [1:0] {ST_RST, ST_RUN, ST_MDU_WAIT} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             mdu_is_div;
   logic             uses_rs1, uses_rs2, legal, is_mdu;
   logic             hazard, br_taken, timeout_hit;
   logic [3:0]       alu_op;

   // Field legality and which source registers the ID instruction reads.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      legal    = 1'b0;
      is_mdu   = 1'b0;
      case (opcode_)
         OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
         OPC_JALR: begin
            uses_rs1 = 1'b1;
            legal    = (funct3_ == 3'd0);
         end
         OPC_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            legal    = (funct3_[2:1] != 2'b01);
         end
         OPC_LOAD: begin
            uses_rs1 = 1'b1;
            legal    = funct3_ inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
         end
         OPC_STORE: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            legal    = (funct3_ <= 3'd2);
         end
         OPC_OPIMM: begin
            uses_rs1 = 1'b1;
            if (funct3_ == 3'd1)      legal = (funct7_ == F7_BASE);
            else if (funct3_ == 3'd5) legal = (funct7_ == F7_BASE) || (funct7_ == F7_ALT);
            else                      legal = 1'b1;
         end
         OPC_OP: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            if (funct7_ == F7_BASE)     legal = 1'b1;
            else if (funct7_ == F7_ALT) legal = (funct3_ == 3'd0) || (funct3_ == 3'd5);
            else if (funct7_ == F7_MULDIV) begin
               is_mdu = (ENABLE_M != 0);
               legal  = is_mdu;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      alu_op = ALUOP_ADD;
      case (funct3_)
         3'd0: alu_op = (opcode_ == OPC_OP && funct7_ == F7_ALT) ? ALUOP_SUB : ALUOP_ADD;
         3'd1: alu_op = ALUOP_SLL;
         3'd2: alu_op = ALUOP_SLT;
         3'd3: alu_op = ALUOP_SLTU;
         3'd4: alu_op = ALUOP_XOR;
         3'd5: alu_op = funct7_[5] ? ALUOP_SRA : ALUOP_SRL;
         3'd6: alu_op = ALUOP_OR;
         default: alu_op = ALUOP_AND;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (funct3_)
         3'd0: br_taken = (rs1_value == rs2_value);
         3'd1: br_taken = (rs1_value != rs2_value);
         3'd4: br_taken = ($signed(rs1_value) <  $signed(rs2_value));
         3'd5: br_taken = ($signed(rs1_value) >= $signed(rs2_value));
         3'd6: br_taken = (rs1_value <  rs2_value);
         3'd7: br_taken = (rs1_value >= rs2_value);
         default: ;
      endcase
   end

   assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                   ((uses_rs1 && ex_rd == id_rs1) || (uses_rs2 && ex_rd == id_rs2));
   assign timeout_hit = (state == ST_MDU_WAIT) && !mdu_done && (cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RST;
         cnt          <= '0;
         mdu_timeout_ <= 1'b0;
         mdu_is_div   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (timeout_hit) mdu_timeout_ <= 1'b1;
         if (mdu_start_)  mdu_is_div   <= funct3_[2];
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RST: begin
            if (cnt == RST_LAST) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (!hazard && legal && is_mdu) begin
               state_nxt = ST_MDU_WAIT;
               cnt_nxt   = '0;
            end
         end
         ST_MDU_WAIT: begin
            if (mdu_done || timeout_hit) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = ST_RST;
      endcase
   end

   always_comb begin
      rst_pc_        = 1'b0;
      sel_pc_        = 1'b0;
      sel_jump_      = 1'b0;
      stall_pc_      = 1'b0;
      stall_IFID_    = 1'b0;
      flush_IFID_    = 1'b0;
      flush_IDEX_    = 1'b0;
      write_regf_en_ = 1'b0;
      write_ram_     = 1'b0;
      sel_alu_a_     = 1'b0;
      sel_alu_b_     = 2'd0;
      sel_rd_value_  = 2'd0;
      op_            = ALUOP_ADD;
      mdu_start_     = 1'b0;
      illegal_       = 1'b0;
      case (state)
         ST_RST: begin
            rst_pc_     = 1'b1;
            flush_IFID_ = 1'b1;
            flush_IDEX_ = 1'b1;
         end
         ST_RUN: begin
            if (hazard) begin
               stall_pc_   = 1'b1;
               stall_IFID_ = 1'b1;
               flush_IDEX_ = 1'b1;
            end else if (!legal) begin
               illegal_ = 1'b1;
            end else if (is_mdu) begin
               mdu_start_  = 1'b1;
               stall_pc_   = 1'b1;
               stall_IFID_ = 1'b1;
            end else begin
               case (opcode_)
                  OPC_OPIMM: begin
                     write_regf_en_ = 1'b1;
                     op_            = alu_op;
                  end
                  OPC_OP: begin
                     write_regf_en_ = 1'b1;
                     sel_alu_b_     = 2'd1;
                     op_            = alu_op;
                  end
                  OPC_LUI: begin
                     write_regf_en_ = 1'b1;
                     op_            = ALUOP_B;
                  end
                  OPC_AUIPC: begin
                     write_regf_en_ = 1'b1;
                     sel_alu_a_     = 1'b1;
                  end
                  OPC_LOAD: begin
                     write_regf_en_ = 1'b1;
                     sel_rd_value_  = 2'd1;
                  end
                  OPC_STORE: write_ram_ = 1'b1;
                  OPC_JAL, OPC_JALR: begin
                     sel_pc_        = 1'b1;
                     sel_jump_      = (opcode_ == OPC_JAL);
                     flush_IFID_    = 1'b1;
                     flush_IDEX_    = 1'b1;
                     sel_alu_a_     = 1'b1;
                     sel_alu_b_     = 2'd2;
                     write_regf_en_ = 1'b1;
                  end
                  OPC_BRANCH: begin
                     sel_jump_ = 1'b1;
                     if (br_taken) begin
                        sel_pc_     = 1'b1;
                        flush_IFID_ = 1'b1;
                        flush_IDEX_ = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_MDU_WAIT: begin
            if (mdu_done) begin
               write_regf_en_ = 1'b1;
               sel_rd_value_  = mdu_is_div ? 2'd3 : 2'd2;
            end else if (timeout_hit) begin
               // Abort: let the stalled instruction leave ID as a bubble.
               flush_IDEX_ = 1'b1;
            end else begin
               stall_pc_   = 1'b1;
               stall_IFID_ = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/pipeline_ctrl_m.md
Name: pipeline_ctrl_m

Overview:
- Parametrised next-generation ID-stage controller for the RV32IM pipeline.
- Decodes opcode/funct fields into datapath selects, ALU op, register-file and RAM write enables.
- Resolves branches and jumps, and runs a configurable reset-hold sequence.
- New versus the current controller: load-use hazard stalls, a multi-cycle MUL/DIV handshake with timeout, an illegal-instruction flag, and a build-time M-extension enable.

Parameters:
- XLEN, 32, width of rs1_value/rs2_value and of branch compares.
- RESET_CYCLES, 2, cycles rst_pc_/flush held after reset release; minimum 1.
- ENABLE_M, 1, 1 decodes the M extension; 0 makes funct7=0000001 on OP illegal.
- MDU_TIMEOUT, 64, maximum MDU_WAIT cycles before abort; minimum 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode_  in  7  ID instruction opcode
- funct3_  in  3  ID funct3
- funct7_  in  7  ID funct7
- rs1_value  in  XLEN  forwarded rs1
- rs2_value  in  XLEN  forwarded rs2
- id_rs1  in  5  ID rs1 index
- id_rs2  in  5  ID rs2 index
- ex_rd  in  5  EX-stage rd index
- ex_is_load  in  1  EX-stage instruction is a load
- mdu_done  in  1  MUL/DIV result valid (1-cycle pulse)
- rst_pc_  out  1  force PC to reset vector
- sel_pc_  out  1  PC takes branch/jump target
- sel_jump_  out  1  target base: 1 = PC (B, JAL), 0 = rs1 (JALR)
- stall_pc_  out  1  hold PC
- stall_IFID_  out  1  hold IF/ID register
- flush_IFID_  out  1  bubble IF/ID
- flush_IDEX_  out  1  bubble ID/EX
- write_regf_en_  out  1  register-file write
- write_ram_  out  1  data-RAM write
- sel_alu_a_  out  1  ALU A: 0 = rs1, 1 = PC
- sel_alu_b_  out  2  ALU B: 0 = imm, 1 = rs2, 2 = constant 4
- sel_rd_value_  out  2  rd source: 0 = ALU, 1 = RAM, 2 = MUL, 3 = DIV
- op_  out  4  `ALUOP_* code from mydefine.sv
- mdu_start_  out  1  1-cycle MUL/DIV launch
- illegal_  out  1  undecodable instruction in ID
- mdu_timeout_  out  1  sticky: MDU timeout occurred; cleared only by reset

Behaviour:
- All outputs are combinational from state and inputs.
- Default output values are 0, with op_ = `ALUOP_ADD.
- State register and counter are async-cleared by rst_n low: state RST, cnt = 0, mdu_timeout_ = 0.

RST state:
- Drives rst_pc_ = 1, flush_IFID_ = 1, flush_IDEX_ = 1; everything else at defaults.
- cnt increments each clock.
- Moves to RUN on the clock where cnt == RESET_CYCLES-1.
- Result: exactly RESET_CYCLES clocks of reset outputs after rst_n rises.

RUN state, priority order:
1. Load-use hazard: ex_is_load, ex_rd != 0, and ex_rd == id_rs1 (any instruction reading rs1), or ex_rd == id_rs2 for R/B/S types.
   - Drives stall_pc_ = 1, stall_IFID_ = 1, flush_IDEX_ = 1.
   - All enables, sel_pc_ and mdu_start_ = 0.
   - Takes precedence over branch resolution and MDU launch.
2. Illegal: unknown opcode, or unknown funct3/funct7 combination.
   - Drives illegal_ = 1 with all enables 0; no state change.
3. RV32I decode:
   - OP-IMM: sel_alu_b_ = 0.
   - OP with funct7 0000000/0100000: sel_alu_b_ = 1.
   - LUI uses `ALUOP_B; AUIPC uses sel_alu_a_ = 1.
   - Loads: sel_rd_value_ = 1.
   - Stores: write_ram_ = 1.
   - JAL/JALR: sel_pc_ = 1, both flushes, sel_alu_a_ = 1, sel_alu_b_ = 2, write_regf_en_ = 1.
   - Branches: sel_jump_ = 1. Taken condition is computed on XLEN bits (signed for BLT/BGE). When taken: sel_pc_ = 1 and both flushes.
4. M-extension (funct7 = 0000001, ENABLE_M = 1):
   - Drives mdu_start_ = 1, stall_pc_ = 1, stall_IFID_ = 1, write_regf_en_ = 0.
   - Moves to MDU_WAIT with cnt = 0.

MDU_WAIT state:
- Drives stall_pc_ = 1 and stall_IFID_ = 1; mdu_start_ = 0.
- mdu_done = 1: write_regf_en_ = 1, stall released, next state RUN.
  - sel_rd_value_ = 2 for funct3 0–3, 3 for funct3 4–7.
- Otherwise cnt increments.
  - At cnt == MDU_TIMEOUT-1 without done: set mdu_timeout_, flush_IDEX_ = 1, no write, return to RUN.
- mdu_done in any state other than MDU_WAIT is ignored.
- rst_n low in any state, including MDU_WAIT: immediate RST; mdu_start_ drops the same instant.

Test Plan:
- Reset: rst_n low 3 cycles, then high → rst_pc_ = 1 for exactly 2 clocks, then 0; ADDI in ID gives write_regf_en_ = 1 and op_ = `ALUOP_ADD.
- Branch: BLT with rs1 = 0xFFFFFFFF, rs2 = 1 → sel_pc_ = 1 and both flushes. BLTU with the same values → sel_pc_ = 0.
- Load-use: ex_is_load = 1, ex_rd = 5, ID = ADD with id_rs2 = 5 → one stall cycle with flush_IDEX_ = 1. Repeat with ex_rd = 0 → no stall.
- MUL/DIV: DIV in ID → mdu_start_ pulses once; stalls persist until mdu_done arrives 10 cycles later; that cycle gives write_regf_en_ = 1 and sel_rd_value_ = 3.
- Timeout: MUL with mdu_done never asserted, MDU_TIMEOUT = 4 → stall for 4 cycles, then mdu_timeout_ = 1 with no write. Mid-wait rst_n low → all outputs return to reset values immediately.
- Illegal: opcode 0x7F → illegal_ = 1 with all enables 0. With ENABLE_M = 0, MUL → illegal_ = 1.
